display_frame_sender: RTL and testbench
=======================================

DISPLAY_FRAME_SENDER -- requirements
Module: display_frame_sender

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: clk cycles per serial bit, legal range 2..255.
REQ-002 SHALL have parameter GAP_BITS, default 1: idle (tx=1) bit periods inserted between consecutive bytes of one frame, legal range 0..3.
REQ-003 SHALL have port clk, input, 1: all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1: request to send one frame, sampled every cycle.
REQ-006 SHALL have port code, input, 16: display code to send, sampled only in the cycle start is accepted.
REQ-007 SHALL have port tx, output, 1: serial line, idle high.
REQ-008 SHALL have port busy, output, 1: high while a frame is in flight.
REQ-009 SHALL have port done, output, 1: one-cycle pulse when a frame completes.
REQ-010 SHALL have port err, output, 1: one-cycle pulse when a request is rejected.

Function
REQ-011 SHALL send a frame as 3 bytes in order: code[15:8], code[7:0], terminator 8'hFF; receiving end shifts data bytes in and commits on 8'hFF.
REQ-012 SHALL encode each byte as 10 bits: start bit 0, data bits LSB first, stop bit 1; each bit held exactly CLKS_PER_BIT cycles.
REQ-013 SHALL insert GAP_BITS*CLKS_PER_BIT idle cycles after byte 0 and after byte 1; none after the terminator.
REQ-014 SHALL use FSM states IDLE, START, DATA, STOP, GAP; byte index 0..2 and bit index 0..7 held in counters.
REQ-015 SHALL, in IDLE with start=1 and neither code byte equal to 8'hFF, latch code, go to START and assert busy on the same rising edge; tx drives the start bit from that edge.
REQ-016 SHALL transition START->DATA after CLKS_PER_BIT cycles, DATA->STOP after 8 bit periods, STOP->GAP (byte 0/1, GAP_BITS>0), STOP->START (byte 0/1, GAP_BITS=0), STOP->IDLE (byte 2), GAP->START after the gap.
REQ-017 SHALL, on the edge leaving the terminator's stop bit, return to IDLE, deassert busy and pulse done for exactly one cycle.
REQ-018 SHALL hold busy high for exactly 30*CLKS_PER_BIT + 2*GAP_BITS*CLKS_PER_BIT cycles per frame.
REQ-019 SHALL ignore start while busy=1 (no err, no latch, in-flight frame unaffected).
REQ-020 SHALL reject start in IDLE when code[15:8]==8'hFF or code[7:0]==8'hFF: pulse err one cycle, stay IDLE, busy=0, tx=1.
REQ-021 SHALL accept a new start in the same cycle done is high (back-to-back frames, no extra idle cycle).
REQ-022 SHALL keep tx glitch-free: tx is a register output, changes only on bit boundaries.
REQ-023 SHALL use changes on code while busy=1 with no effect on the frame.

Reset
REQ-024 SHALL, while rst_n=0, force tx=1, busy=0, done=0, err=0, FSM=IDLE, all counters and latched code to 0, immediately and regardless of clk.
REQ-025 SHALL abort any frame in flight on reset; after rst_n rises, first accepted start begins a fresh frame at byte 0.

Verification
REQ-026 SHALL cover: CLKS_PER_BIT=4, GAP_BITS=1, code=16'h1234, one-cycle start -> tx bytes 8'h12, 8'h34, 8'hFF LSB first, 4-cycle bits, 4-cycle gaps, busy high 128 cycles, single done pulse.
REQ-027 SHALL cover: code=16'h12FF with start -> err one cycle, busy stays 0, tx stays 1; then code=16'hFF00 -> same.
REQ-028 SHALL cover: start re-asserted at cycle 50 of a frame with code=16'hABCD -> ignored, frame still 8'h12,8'h34,8'hFF, no err.
REQ-029 SHALL cover: start held high continuously, GAP_BITS=0, codes 16'h0102 then 16'h0304 -> second frame start bit on the edge done pulses, busy never drops between frames, 120 cycles per frame.
REQ-030 SHALL cover: rst_n pulsed low mid-DATA of byte 1 -> tx=1, busy=0 asynchronously; next start with 16'h5566 sends complete frame 8'h55,8'h66,8'hFF.
REQ-031 SHALL cover: loopback into the team serial receiver and frame assembler -> display code register equals sent code after the terminator, unchanged after data bytes only.

Source files
------------

// File: rtl/display_frame_sender.sv
// Serial sender for a 16-bit display code: two data bytes (high first) then an
// 8'hFF terminator, each byte framed as start/8 data LSB-first/stop.
module display_frame_sender #(
  parameter int CLKS_PER_BIT = 16,
  parameter int GAP_BITS     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] code,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [2:0]  fsm_state
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;

  localparam logic [7:0] CPB_LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [1:0] GAP_LAST = 2'(GAP_BITS - 1);

  state_t      state, state_n;
  logic [7:0]  clk_cnt, clk_cnt_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [1:0]  byte_idx, byte_idx_n;
  logic [1:0]  gap_cnt, gap_cnt_n;
  logic [15:0] code_q, code_n;
  logic        tx_n, busy_n, done_n, err_n;
  logic        bit_end, code_ok, launch;
  logic [7:0]  cur_byte;

  assign fsm_state = state;
  assign bit_end   = (clk_cnt == CPB_LAST);
  assign code_ok   = (code[15:8] != 8'hFF) && (code[7:0] != 8'hFF);

  always_comb begin
    case (byte_idx)
      2'd0:    cur_byte = code_q[15:8];
      2'd1:    cur_byte = code_q[7:0];
      default: cur_byte = 8'hFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      gap_cnt  <= '0;
      code_q   <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      clk_cnt  <= clk_cnt_n;
      bit_idx  <= bit_idx_n;
      byte_idx <= byte_idx_n;
      gap_cnt  <= gap_cnt_n;
      code_q   <= code_n;
      tx       <= tx_n;
      busy     <= busy_n;
      done     <= done_n;
      err      <= err_n;
    end
  end

  always_comb begin
    state_n    = state;
    clk_cnt_n  = clk_cnt;
    bit_idx_n  = bit_idx;
    byte_idx_n = byte_idx;
    gap_cnt_n  = gap_cnt;
    code_n     = code_q;
    tx_n       = tx;
    busy_n     = busy;
    done_n     = 1'b0;
    err_n      = 1'b0;
    // A request may be taken in IDLE or on the very edge the terminator ends.
    launch     = (state == IDLE) || (state == STOP && bit_end && byte_idx == 2'd2);

    if (state != IDLE) clk_cnt_n = bit_end ? 8'd0 : clk_cnt + 8'd1;

    case (state)
      START: if (bit_end) begin
        state_n   = DATA;
        bit_idx_n = 3'd0;
        tx_n      = cur_byte[0];
      end
      DATA: if (bit_end) begin
        if (bit_idx == 3'd7) begin
          state_n = STOP;
          tx_n    = 1'b1;
        end else begin
          bit_idx_n = bit_idx + 3'd1;
          tx_n      = cur_byte[bit_idx + 3'd1];
        end
      end
      STOP: if (bit_end) begin
        if (byte_idx == 2'd2) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else if (GAP_BITS == 0) begin
          state_n    = START;
          tx_n       = 1'b0;
          byte_idx_n = byte_idx + 2'd1;
        end else begin
          state_n   = GAP;
          gap_cnt_n = 2'd0;
        end
      end
      GAP: if (bit_end) begin
        if (gap_cnt == GAP_LAST) begin
          state_n    = START;
          tx_n       = 1'b0;
          byte_idx_n = byte_idx + 2'd1;
        end else begin
          gap_cnt_n = gap_cnt + 2'd1;
        end
      end
      default: ;
    endcase

    if (launch && start) begin
      if (code_ok) begin
        state_n    = START;
        busy_n     = 1'b1;
        tx_n       = 1'b0;
        code_n     = code;
        clk_cnt_n  = 8'd0;
        bit_idx_n  = 3'd0;
        byte_idx_n = 2'd0;
        gap_cnt_n  = 2'd0;
      end else begin
        err_n = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_display_frame_sender.sv
// Bench for display_frame_sender: two instances (gap 1 and gap 0) against a
// frame-level model, plus a loopback receiver/assembler on the gapped one.
module tb_display_frame_sender;
  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] code = 16'h0000;
  logic [1:0]  tx_v, busy_v, done_v, err_v;
  logic [2:0]  st_a, st_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  display_frame_sender #(.CLKS_PER_BIT(CPB), .GAP_BITS(1)) dut_gap (
    .clk(clk), .rst_n(rst_n), .start(start), .code(code),
    .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]), .err(err_v[0]),
    .fsm_state(st_a)
  );

  display_frame_sender #(.CLKS_PER_BIT(CPB), .GAP_BITS(0)) dut_nogap (
    .clk(clk), .rst_n(rst_n), .start(start), .code(code),
    .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]), .err(err_v[1]),
    .fsm_state(st_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- frame-level model ----------------
  function automatic int frame_len(input int g);
    return (30 + 2 * g) * CPB;
  endfunction

  // Line level at cycle pos of a frame: each byte is 10 bit periods plus g idle periods.
  function automatic logic frame_bit(input logic [15:0] c, input int pos, input int g);
    int period, k, b;
    logic [7:0] by;
    period = pos / CPB;
    k = period / (10 + g);
    b = period % (10 + g);
    by = (k == 0) ? c[15:8] : (k == 1) ? c[7:0] : 8'hFF;
    if (b == 0) return 1'b0;
    if (b <= 8) return by[b-1];
    return 1'b1;
  endfunction

  int          m_pos[2] = '{-1, -1};
  logic [15:0] m_code[2];
  logic [1:0]  m_tx = 2'b11, m_busy = 2'b00, m_done = 2'b00, m_err = 2'b00;

  initial forever begin
    @(posedge clk or negedge rst_n);
    for (int i = 0; i < 2; i++) begin
      int g;
      g = (i == 0) ? 1 : 0;
      if (!rst_n) begin
        m_pos[i] = -1; m_code[i] = 16'h0;
        m_tx[i] = 1'b1; m_busy[i] = 1'b0; m_done[i] = 1'b0; m_err[i] = 1'b0;
      end else begin
        m_done[i] = 1'b0;
        m_err[i]  = 1'b0;
        if (m_pos[i] >= 0) begin
          m_pos[i]++;
          if (m_pos[i] == frame_len(g)) begin
            m_pos[i]  = -1;
            m_done[i] = 1'b1;
          end
        end
        if (m_pos[i] < 0 && start) begin
          if (code[15:8] == 8'hFF || code[7:0] == 8'hFF) m_err[i] = 1'b1;
          else begin
            m_pos[i]  = 0;
            m_code[i] = code;
          end
        end
        m_tx[i]   = (m_pos[i] < 0) ? 1'b1 : frame_bit(m_code[i], m_pos[i], g);
        m_busy[i] = (m_pos[i] >= 0);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("tx[%0d]", i),   32'(tx_v[i]),   32'(m_tx[i]));
      check($sformatf("busy[%0d]", i), 32'(busy_v[i]), 32'(m_busy[i]));
      check($sformatf("done[%0d]", i), 32'(done_v[i]), 32'(m_done[i]));
      check($sformatf("err[%0d]", i),  32'(err_v[i]),  32'(m_err[i]));
    end
  end

  // ---------------- loopback receiver + frame assembler ----------------
  logic        rx_en = 1'b0;
  logic [7:0]  rx_bytes[$];
  logic [15:0] shift_reg = 16'h0, disp_code = 16'h0, disp_at_term = 16'h0;

  initial forever begin
    @(negedge clk);
    if (tx_v[0] == 1'b0) begin
      logic [7:0] b;
      repeat (CPB + CPB / 2) @(negedge clk);
      for (int j = 0; j < 8; j++) begin
        b[j] = tx_v[0];
        if (j < 7) repeat (CPB) @(negedge clk);
      end
      repeat (CPB) @(negedge clk);
      if (rx_en) begin
        rx_bytes.push_back(b);
        if (b == 8'hFF) begin
          disp_at_term = disp_code;
          disp_code    = shift_reg;
        end else begin
          shift_reg = {shift_reg[7:0], b};
        end
      end
    end
  end

  function automatic logic [23:0] rx_word();
    if (rx_bytes.size() != 3) return 24'h0;
    return {rx_bytes[0], rx_bytes[1], rx_bytes[2]};
  endfunction

  task automatic rx_clear();
    rx_bytes.delete();
    shift_reg    = 16'h0;
    disp_code    = 16'h0;
    disp_at_term = 16'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int busy_a, busy_b, done_a, done_b, err_a, err_b, tx_low, busy_gap_b;
    int first_done_b, second_done_b;
    logic tx_at_done, busy_at_done;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx", 32'(tx_v), 32'h3);
    check("reset_busy", 32'(busy_v), 32'h0);
    check("reset_done", 32'(done_v), 32'h0);
    check("reset_err", 32'(err_v), 32'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single frame 16'h1234.
    rx_clear(); rx_en = 1'b1;
    code = 16'h1234; start = 1'b1;
    @(negedge clk); start = 1'b0;
    busy_a = 0; busy_b = 0; done_a = 0; done_b = 0; err_a = 0;
    for (int k = 0; k < 200; k++) begin
      busy_a += int'(busy_v[0]); busy_b += int'(busy_v[1]);
      done_a += int'(done_v[0]); done_b += int'(done_v[1]);
      err_a  += int'(err_v[0]) + int'(err_v[1]);
      @(negedge clk);
    end
    check("f1_busy_gap", busy_a, 128);
    check("f1_busy_nogap", busy_b, 120);
    check("f1_done_gap", done_a, 1);
    check("f1_done_nogap", done_b, 1);
    check("f1_err", err_a, 0);
    check("f1_rx_bytes", rx_word(), 24'h1234FF);
    check("f1_disp_before_term", disp_at_term, 16'h0000);
    check("f1_disp_code", disp_code, 16'h1234);

    // Rejected codes.
    rx_en = 1'b0;
    for (int t = 0; t < 2; t++) begin
      code = (t == 0) ? 16'h12FF : 16'hFF00; start = 1'b1;
      @(negedge clk); start = 1'b0;
      err_a = 0; err_b = 0; busy_a = 0; tx_low = 0;
      for (int k = 0; k < 4; k++) begin
        err_a  += int'(err_v[0]); err_b += int'(err_v[1]);
        busy_a += int'(busy_v[0]) + int'(busy_v[1]);
        tx_low += int'(!tx_v[0]) + int'(!tx_v[1]);
        @(negedge clk);
      end
      check($sformatf("rej%0d_err_gap", t), err_a, 1);
      check($sformatf("rej%0d_err_nogap", t), err_b, 1);
      check($sformatf("rej%0d_busy", t), busy_a, 0);
      check($sformatf("rej%0d_tx_low", t), tx_low, 0);
    end

    // Start re-asserted mid-frame must be ignored.
    rx_clear(); rx_en = 1'b1;
    code = 16'h1234; start = 1'b1;
    @(negedge clk); start = 1'b0;
    err_a = 0; busy_a = 0;
    for (int k = 0; k < 200; k++) begin
      if (k == 49) begin code = 16'hABCD; start = 1'b1; end
      if (k == 50) start = 1'b0;
      err_a  += int'(err_v[0]) + int'(err_v[1]);
      busy_a += int'(busy_v[0]);
      @(negedge clk);
    end
    check("mid_err", err_a, 0);
    check("mid_busy_gap", busy_a, 128);
    check("mid_rx_bytes", rx_word(), 24'h1234FF);
    check("mid_disp_code", disp_code, 16'h1234);

    // Back-to-back frames with start held high.
    rx_en = 1'b0;
    code = 16'h0102; start = 1'b1;
    @(negedge clk); code = 16'h0304;
    first_done_b = -1; second_done_b = -1; busy_gap_b = 0; done_a = 0;
    tx_at_done = 1'b1; busy_at_done = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (k < 240) busy_gap_b += int'(!busy_v[1]);
      done_a += int'(done_v[0]);
      if (done_v[1]) begin
        if (first_done_b < 0) begin
          first_done_b = k; tx_at_done = tx_v[1]; busy_at_done = busy_v[1];
        end else if (second_done_b < 0) second_done_b = k;
      end
      if (k == 120) start = 1'b0;
      @(negedge clk);
    end
    check("b2b_first_done", first_done_b, 120);
    check("b2b_second_done", second_done_b, 240);
    check("b2b_tx_at_done", 32'(tx_at_done), 32'h0);
    check("b2b_busy_at_done", 32'(busy_at_done), 32'h1);
    check("b2b_busy_gap", busy_gap_b, 0);
    check("b2b_done_gap_inst", done_a, 1);

    // Asynchronous reset in the middle of byte 1, then a fresh frame.
    code = 16'h1234; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (49) @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_tx", 32'(tx_v), 32'h3);
    check("rst_async_busy", 32'(busy_v), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    rx_clear(); rx_en = 1'b1;
    code = 16'h5566; start = 1'b1;
    @(negedge clk); start = 1'b0;
    busy_a = 0;
    for (int k = 0; k < 200; k++) begin
      busy_a += int'(busy_v[0]);
      @(negedge clk);
    end
    check("post_rst_busy", busy_a, 128);
    check("post_rst_rx_bytes", rx_word(), 24'h5566FF);
    check("post_rst_disp_code", disp_code, 16'h5566);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
